// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
// The decoder and the hazard unit use the same MDctr encoding.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110,
    MD_RSVD  = 3'b111
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 5;

  function automatic logic md_is_mult(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_md_compute.sv
// Combinational 32x32 multiply / divide producing {hi, lo}.
// Division runs on magnitudes; signs are restored afterwards for div.
module md_compute
  import mult_div_unit_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  md_op_e      op,
  output logic [63:0] res
);

  logic [63:0] prod_s, prod_u;
  logic        sgn;
  logic [31:0] dvd, dvs, quo, rem;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'b0, a} * {32'b0, b};

  assign sgn = (op == MD_DIV);
  assign dvd = (sgn && a[31]) ? -a : a;
  assign dvs = (sgn && b[31]) ? -b : b;
  // Guard keeps the divider free of X when the zero-divisor rule applies.
  assign quo = (dvs == '0) ? '0 : dvd / dvs;
  assign rem = (dvs == '0) ? '0 : dvd % dvs;

  always_comb begin
    res = '0;
    case (op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV, MD_DIVU: begin
        if (b == '0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          res = {32'h0, 32'h8000_0000};
        end else begin
          res[31:0]  = (sgn && (a[31] ^ b[31])) ? -quo : quo;
          res[63:32] = (sgn && a[31]) ? -rem : rem;
        end
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit owning HI/LO. Results are computed at issue,
// parked in a pending register, and committed when the latency counter expires.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDctr,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d;
  md_op_e           op;
  logic [63:0]      res;

  assign op = md_op_e'(MDctr);

  md_compute u_compute (
    .a   (A),
    .b   (B),
    .op  (op),
    .res (res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (md_is_mult(op) || md_is_div(op)) begin
            pend_d  = res;
            cnt_d   = md_is_mult(op) ? MULT_LAT : DIV_LAT;
            busy_d  = 1'b1;
            state_d = S_BUSY;
          end else if (op == MD_MTHI) begin
            hi_d = A;
          end else if (op == MD_MTLO) begin
            lo_d = A;
          end
        end
      end
      S_BUSY: begin
        // Any start arriving here is dropped; the hazard unit should prevent it.
        if (cnt_q == '0) begin
          hi_d    = pend_q[63:32];
          lo_d    = pend_q[31:0];
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO updates
// with their due cycle; a negedge monitor retires them and checks busy/HI/LO.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int NM = 5;
  localparam int ND = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic [2:0]  MDctr = '0;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] HI, LO;

  mult_div_unit #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .A       (A),
    .B       (B),
    .MDctr   (MDctr),
    .start   (start),
    .busy    (busy),
    .HI      (HI),
    .LO      (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          set_hi;
    bit          set_lo;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          busy_first = -10, busy_last = -10;
  logic [31:0] m_hi = '0, m_lo = '0;
  bit          mon_en = 1'b0;
  int          n_cmp = 0, n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference behaviour: plain SV arithmetic on the architectural rules.
  task automatic model_issue(input int t, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b);
    exp_t   e;
    longint sa, sb, p;
    int     ia, ib;
    if (t - 1 <= busy_last) return;
    e.due = t; e.set_hi = 1'b0; e.set_lo = 1'b0; e.hi = '0; e.lo = '0;
    case (op)
      3'd1: begin
        sa = longint'($signed(a)); sb = longint'($signed(b)); p = sa * sb;
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      3'd2: begin
        p = longint'({32'b0, a}) * longint'({32'b0, b});
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      3'd3: begin
        if (b == 0) begin e.lo = 32'hFFFF_FFFF; e.hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin e.lo = 32'h8000_0000; e.hi = 0; end
        else begin
          ia = $signed(a); ib = $signed(b);
          e.lo = ia / ib; e.hi = ia % ib;
        end
      end
      3'd4: begin
        if (b == 0) begin e.lo = 32'hFFFF_FFFF; e.hi = a; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
      3'd5: begin e.set_hi = 1'b1; e.hi = a; sb_q.push_back(e); end
      3'd6: begin e.set_lo = 1'b1; e.lo = a; sb_q.push_back(e); end
      default: ;
    endcase
    if (op >= 3'd1 && op <= 3'd4) begin
      int n;
      n = (op <= 3'd2) ? NM : ND;
      busy_first = t;
      busy_last  = t + n - 1;
      e.due = t + n; e.set_hi = 1'b1; e.set_lo = 1'b1;
      sb_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        if (sb_q[0].set_hi) m_hi = sb_q[0].hi;
        if (sb_q[0].set_lo) m_lo = sb_q[0].lo;
        void'(sb_q.pop_front());
      end
      chk("busy", {31'b0, busy}, {31'b0, (cyc >= busy_first && cyc <= busy_last)});
      chk("HI", HI, m_hi);
      chk("LO", LO, m_lo);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    MDctr = op; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    model_issue(cyc, op, a, b);
    start = 1'b0; MDctr = 3'd0; A = $urandom; B = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [31:0] ra, rb;
    #3;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_HI", HI, 32'h0);
    chk("rst_LO", LO, 32'h0);
    #9 reset_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    issue(3'd1, 32'hFFFF_FFFD, 32'd7);         idle(8);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2);         idle(8);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);         idle(12);
    issue(3'd4, 32'd7, 32'd0);                 idle(12);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF); idle(3);
    issue(3'd1, 32'd2, 32'd3);                 idle(12);
    issue(3'd5, 32'h1234, 32'd0);
    issue(3'd6, 32'h5678, 32'd0);              idle(3);
    // Start landing on the edge where busy falls must be dropped.
    issue(3'd1, 32'd11, 32'd13);               idle(NM - 1);
    issue(3'd6, 32'hDEAD, 32'd0);              idle(3);

    issue(3'd4, 32'd100, 32'd7);               idle(2);
    #1 reset_n = 1'b0;
    sb_q.delete(); m_hi = '0; m_lo = '0; busy_first = -10; busy_last = -10;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_HI", HI, 32'h0);
    chk("midrst_LO", LO, 32'h0);
    #1 reset_n = 1'b1;
    idle(15);

    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 9);
        3: ra = -($urandom_range(0, 100));
        default: ;
      endcase
      issue(3'($urandom_range(0, 7)), ra, rb);
      idle($urandom_range(0, 12));
    end
    idle(ND + 2);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
